// File: rtl/rf_wb_pkg.sv
// Shared types and constants for the register-file writeback arbiter.
//   RF_DATA_W / RF_ADDR_W : default write data / register address widths
//   REG_ZERO              : architectural zero register (writes to it are dropped)
//   wb_entry_t            : LSU return buffer entry {wa, wd, kill}
//   wb_sel_e              : write-port owner for the current cycle
package rf_wb_pkg;

  localparam int unsigned RF_DATA_W = 32;
  localparam int unsigned RF_ADDR_W = 5;

  localparam logic [RF_ADDR_W-1:0] REG_ZERO = '0;

  typedef struct packed {
    logic [RF_ADDR_W-1:0] wa;
    logic [RF_DATA_W-1:0] wd;
    logic                 kill;
  } wb_entry_t;

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_POP  = 2'd2
  } wb_sel_e;

endpackage

// File: rtl/rf_writeback_arbiter_if.sv
// Bus bundle between the execute/LSU/decode stages and the writeback arbiter.
//   ALU path : alu_valid, alu_wa, alu_wd -> ; <- alu_stall
//   LSU path : lsu_valid, lsu_wa, lsu_wd -> ; <- lsu_ready
//   Hazards  : ra1, ra2 -> ; <- pend1, pend2
//   RF port  : <- WA, WE, WD
// master = producer/consumer side, slave = arbiter side.
interface rf_writeback_arbiter_if #(
  parameter int unsigned DATA_W = rf_wb_pkg::RF_DATA_W,
  parameter int unsigned ADDR_W = rf_wb_pkg::RF_ADDR_W
) ();

  logic              alu_valid;
  logic [ADDR_W-1:0] alu_wa;
  logic [DATA_W-1:0] alu_wd;
  logic              alu_stall;

  logic              lsu_valid;
  logic              lsu_ready;
  logic [ADDR_W-1:0] lsu_wa;
  logic [DATA_W-1:0] lsu_wd;

  logic [ADDR_W-1:0] ra1;
  logic [ADDR_W-1:0] ra2;
  logic              pend1;
  logic              pend2;

  logic [ADDR_W-1:0] WA;
  logic              WE;
  logic [DATA_W-1:0] WD;

  modport master (
    output alu_valid, alu_wa, alu_wd, lsu_valid, lsu_wa, lsu_wd, ra1, ra2,
    input  alu_stall, lsu_ready, pend1, pend2, WA, WE, WD
  );

  modport slave (
    input  alu_valid, alu_wa, alu_wd, lsu_valid, lsu_wa, lsu_wd, ra1, ra2,
    output alu_stall, lsu_ready, pend1, pend2, WA, WE, WD
  );

endinterface

// File: rtl/wb_kill_fifo.sv
// Circular LSU return buffer with per-entry kill bits and live-entry address match.
//   clk, rst_n            : clock, synchronous active-low reset
//   push, push_wa/wd      : enqueue (caller guarantees not full)
//   pop                   : dequeue head (caller guarantees not empty)
//   kill_en, kill_addr    : mark every live entry (and a same-cycle push) with wa==kill_addr
//   match_a1/a2, hit1/2_c : live, non-killed entry targets the given nonzero address
//   head_c, empty_c, full_c : head entry and occupancy flags from registered state
module wb_kill_fifo
  import rf_wb_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 push,
  input  logic [RF_ADDR_W-1:0] push_wa,
  input  logic [RF_DATA_W-1:0] push_wd,
  input  logic                 pop,
  input  logic                 kill_en,
  input  logic [RF_ADDR_W-1:0] kill_addr,
  input  logic [RF_ADDR_W-1:0] match_a1,
  input  logic [RF_ADDR_W-1:0] match_a2,
  output logic                 hit1_c,
  output logic                 hit2_c,
  output wb_entry_t            head_c,
  output logic                 empty_c,
  output logic                 full_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  wb_entry_t        mem [DEPTH];
  logic [PTR_W-1:0] head;
  logic [PTR_W-1:0] tail;
  logic [CNT_W-1:0] count;
  logic [DEPTH-1:0] live;
  logic [PTR_W-1:0] off;
  logic             push_ok;
  logic             pop_ok;

  assign empty_c = (count == '0);
  assign full_c  = (count == CNT_W'(DEPTH));
  assign head_c  = mem[head];
  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;

  // Slot i is live when its distance from head is below the occupancy.
  always_comb begin
    live = '0;
    off  = '0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      off     = PTR_W'(i) - head;
      live[i] = (CNT_W'(off) < count);
    end
  end

  // Hazard match against live, non-killed entries; x0 never matches.
  always_comb begin
    hit1_c = 1'b0;
    hit2_c = 1'b0;
    for (int i = 0; i < int'(DEPTH); i++) begin
      if (live[i] && !mem[i].kill) begin
        if (mem[i].wa == match_a1 && match_a1 != REG_ZERO) hit1_c = 1'b1;
        if (mem[i].wa == match_a2 && match_a2 != REG_ZERO) hit2_c = 1'b1;
      end
    end
  end

  // Storage, pointers and kill marking; a same-cycle push counts as older than the kill.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      head  <= '0;
      tail  <= '0;
      count <= '0;
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
    end else begin
      if (kill_en) begin
        for (int i = 0; i < int'(DEPTH); i++) begin
          if (live[i] && mem[i].wa == kill_addr) mem[i].kill <= 1'b1;
        end
      end
      if (push_ok) begin
        mem[tail] <= '{wa: push_wa, wd: push_wd, kill: (kill_en && push_wa == kill_addr)};
        tail      <= tail + PTR_W'(1);
      end
      if (pop_ok) head <= head + PTR_W'(1);
      case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rf_writeback_arbiter.sv
// Register-file write-port arbiter: ALU results take priority, LSU load returns are
// buffered and drained in idle cycles or forcibly after STARVE_LIM bypassed cycles.
// An issued ALU write kills queued older LSU writes to the same register.
//   clk, rst_n : clock, synchronous active-low reset
//   bus        : ALU request/stall, LSU valid/ready, decode hazard query, RF WA/WE/WD
module rf_writeback_arbiter
  import rf_wb_pkg::*;
#(
  parameter int unsigned DATA_W     = RF_DATA_W,
  parameter int unsigned ADDR_W     = RF_ADDR_W,
  parameter int unsigned FIFO_DEPTH = 2,
  parameter int unsigned STARVE_LIM = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  rf_writeback_arbiter_if.slave  bus
);

  localparam int unsigned SC_W = $clog2(STARVE_LIM + 1);

  logic [SC_W-1:0]   starve_cnt;
  logic [SC_W-1:0]   starve_nxt;
  logic [ADDR_W-1:0] wa_q;
  logic [ADDR_W-1:0] wa_nxt;
  logic [DATA_W-1:0] wd_q;
  logic [DATA_W-1:0] wd_nxt;
  logic              we_q;
  logic              we_nxt;

  wb_sel_e   sel_c;
  wb_entry_t head_c;
  logic      fifo_empty_c;
  logic      fifo_full_c;
  logic      lsu_ready_c;
  logic      push_c;
  logic      stall_c;
  logic      hit1_c;
  logic      hit2_c;

  // No pass-through: readiness comes only from registered occupancy.
  assign lsu_ready_c = !fifo_full_c && rst_n;
  assign push_c      = bus.lsu_valid && lsu_ready_c && (bus.lsu_wa != REG_ZERO);
  assign stall_c     = (starve_cnt == SC_W'(STARVE_LIM)) && !fifo_empty_c;

  wb_kill_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (rst_n),
    .push      (push_c),
    .push_wa   (bus.lsu_wa),
    .push_wd   (bus.lsu_wd),
    .pop       (sel_c == SEL_POP),
    .kill_en   (sel_c == SEL_ALU),
    .kill_addr (bus.alu_wa),
    .match_a1  (bus.ra1),
    .match_a2  (bus.ra2),
    .hit1_c    (hit1_c),
    .hit2_c    (hit2_c),
    .head_c    (head_c),
    .empty_c   (fifo_empty_c),
    .full_c    (fifo_full_c)
  );

  // Port owner selection, next write-port values and starvation counter.
  always_comb begin
    sel_c      = SEL_NONE;
    we_nxt     = 1'b0;
    wa_nxt     = wa_q;
    wd_nxt     = wd_q;
    starve_nxt = starve_cnt;

    if (stall_c)                                        sel_c = SEL_POP;
    else if (bus.alu_valid && bus.alu_wa != REG_ZERO)   sel_c = SEL_ALU;
    else if (bus.alu_valid)                             sel_c = SEL_NONE; // x0 write consumed
    else if (!fifo_empty_c)                             sel_c = SEL_POP;

    case (sel_c)
      SEL_ALU: begin
        we_nxt = 1'b1;
        wa_nxt = bus.alu_wa;
        wd_nxt = bus.alu_wd;
      end
      SEL_POP: begin
        // A killed entry burns the slot but leaves the port values untouched.
        we_nxt = !head_c.kill;
        if (!head_c.kill) begin
          wa_nxt = head_c.wa;
          wd_nxt = head_c.wd;
        end
      end
      default: ;
    endcase

    if (fifo_empty_c || sel_c == SEL_POP)        starve_nxt = '0;
    else if (starve_cnt != SC_W'(STARVE_LIM))    starve_nxt = starve_cnt + SC_W'(1);
  end

  // Registered write port and starvation state.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      we_q       <= 1'b0;
      wa_q       <= '0;
      wd_q       <= '0;
      starve_cnt <= '0;
    end else begin
      we_q       <= we_nxt;
      wa_q       <= wa_nxt;
      wd_q       <= wd_nxt;
      starve_cnt <= starve_nxt;
    end
  end

  assign bus.alu_stall = stall_c;
  assign bus.lsu_ready = lsu_ready_c;
  assign bus.pend1     = hit1_c;
  assign bus.pend2     = hit2_c;
  assign bus.WA        = wa_q;
  assign bus.WE        = we_q;
  assign bus.WD        = wd_q;

endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Write-side front end for the core's 32x32 register file: it owns the WA/WE/WD write port.
- Merges two producers onto the single write port:
  - the single-cycle ALU result path, which has priority and no back-pressure except a starvation stall;
  - the multi-cycle LSU load-return path, which has a valid/ready handshake and a small FIFO.
- Enforces program order on same-register writes.
- Exports pending-write hazard flags for the decode stage's two read addresses.

Parameters:
- DATA_W, 32, write data width
- ADDR_W, 5, register address width
- FIFO_DEPTH, 2, LSU return buffer entries (power of 2, >=2)
- STARVE_LIM, 4, consecutive cycles a non-empty FIFO may be bypassed by the ALU before a forced drain

Ports:
- clk  in  1  clock, all state on posedge
- rst_n  in  1  synchronous active-low reset
- alu_valid  in  1  ALU writeback request this cycle
- alu_wa  in  ADDR_W  ALU destination register
- alu_wd  in  DATA_W  ALU result
- alu_stall  out  1  ALU request not consumed this cycle; upstream holds
- lsu_valid  in  1  load-return data valid
- lsu_ready  out  1  FIFO can accept
- lsu_wa  in  ADDR_W  load destination register
- lsu_wd  in  DATA_W  load data
- ra1  in  ADDR_W  decode read address 1
- ra2  in  ADDR_W  decode read address 2
- pend1  out  1  live queued write targets ra1
- pend2  out  1  live queued write targets ra2
- WA  out  ADDR_W  register file write address (registered)
- WE  out  1  register file write enable (registered)
- WD  out  DATA_W  register file write data (registered)

Behaviour:
- Interface (already decided): one clock, clk; reset rst_n is synchronous and active-low.
- Reset (rst_n low at posedge):
  - WE=0, WA=0, WD=0;
  - FIFO empty, all kill bits cleared, starve_cnt=0.
  - lsu_ready is forced to 0 while rst_n=0.
- lsu_ready:
  - equals (count < FIFO_DEPTH) && rst_n, from registered state only;
  - no pass-through when full, even if a pop occurs in the same cycle.
- LSU push:
  - occurs on lsu_valid && lsu_ready.
  - lsu_wa==0: handshake completes, nothing is enqueued.
- Issue selection, evaluated each cycle from registered state; the winner is registered onto WA/WD/WE at the next posedge (latency 1):
  1. alu_stall = (starve_cnt == STARVE_LIM) && FIFO non-empty. If alu_stall, pop the FIFO head; the ALU request is not consumed.
  2. Else if alu_valid && alu_wa != 0: issue the ALU write (WE=1).
  3. Else if alu_valid && alu_wa == 0: consume the request, WE=0. The FIFO does not pop this cycle.
  4. Else if FIFO non-empty: pop the head.
  5. Else WE=0.
- Pop output: WE = !kill[head], WA/WD from the head entry. A killed entry still consumes the pop slot.
- starve_cnt:
  - increments when the FIFO is non-empty and not popped;
  - clears on any pop or when the FIFO is empty;
  - saturates at STARVE_LIM.
- Ordering rule: an issued ALU write to register X sets kill on every FIFO entry with wa==X. This covers entries present at cycle start and an entry pushed in the same cycle; the LSU push is treated as older.
- Hazard flags:
  - pend1 = (ra1 != 0) && any valid, non-killed entry has wa==ra1, combinational from registered FIFO state. pend2 is identical for ra2.
  - The flags do not reflect WA/WE in flight; the register file itself covers that cycle.
- Simultaneous push and pop on a non-full FIFO: both take effect and count is unchanged.
- WD and WA hold their previous values when WE=0.

Decomposition:
- Package rf_wb_pkg holds:
  - DATA_W/ADDR_W defaults;
  - FIFO entry struct {wa, wd, kill};
  - the REG_ZERO constant.
- Sub-module wb_kill_fifo, a circular FIFO with:
  - push/pop;
  - a kill_en/kill_addr port;
  - two match-address ports returning live hits (pend1/pend2).
- The top level holds the arbiter, starve counter and output register.

Test Plan:
1. Reset mid-traffic: FIFO holds 2 entries, rst_n=0 for 1 cycle -> WE=0, WA=0, WD=0, lsu_ready=0 during reset and 1 after; the old entries are never written.
2. Back-to-back ALU writes with the FIFO empty: alu_wa=3/wd=0x11, then 4/0x22 -> WE=1 with WA=3,WD=0x11 one cycle later, then WA=4,WD=0x22; alu_stall=0 throughout.
3. Starvation:
   - Setup: push LSU wa=7,wd=0xAA; hold alu_valid=1 (wa=5) continuously.
   - 4 ALU writes issue, then alu_stall=1 for one cycle;
   - next cycle WA=7,WD=0xAA,WE=1;
   - the held ALU request issues the following cycle.
4. Ordering kill:
   - Setup: FIFO holds wa=9,wd=0x1; ALU issues wa=9,wd=0x2 while pend1 (ra1=9) is 1.
   - pend1 drops to 0 the cycle after the ALU issue;
   - the later pop produces WE=0, and register 9 ends at 0x2.
5. Full FIFO back-pressure: FIFO_DEPTH=2 full, ALU busy every cycle -> lsu_ready=0; an lsu_valid pulse is not accepted; lsu_ready rises the cycle after the first pop.
6. x0 writes: lsu_wa=0 with lsu_ready=1 completes with no enqueue (count unchanged); alu_wa=0 -> WE=0; ra1=0 -> pend1=0 always.
